// File: rtl/life_cell_evolve.sv
// Per-cell Game of Life generation engine: mirrors the confirmed seed during setup, then
// applies the Life rule once per board tick. Optional macro: LIFE_HIGHLIFE_RULE_EN (B36/S23).
module life_cell_evolve #(
  parameter int unsigned AGE_WIDTH   = 4,
  parameter int unsigned STABLE_GENS = 3
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_seed,
  input  logic                 i_start_game_switch,
  input  logic                 i_pause_switch,
  input  logic                 i_gen_tick,
  input  logic [7:0]           i_neighbors,
  output logic                 o_alive,
  output logic                 o_changed,
  output logic [AGE_WIDTH-1:0] o_age,
  output logic                 o_stable
);

  localparam logic [AGE_WIDTH-1:0] AgeMax    = '1;
  localparam logic [3:0]           UnchMax   = 4'hF;
  localparam logic [4:0]           StableThr = 5'(STABLE_GENS);

  typedef enum logic [1:0] {StSetup = 2'd0, StRun = 2'd1, StEval = 2'd2} state_e;

  state_e               r_state, w_state_next;
  logic                 r_alive, r_changed, r_stable;
  logic [AGE_WIDTH-1:0] r_age;
  logic [3:0]           r_nbr_cnt, r_unch_cnt;

  logic                 w_load_seed, w_sample, w_eval;
  logic [3:0]           w_popcount;
  logic                 w_survive, w_birth, w_alive_next, w_flip;
  logic [AGE_WIDTH-1:0] w_age_next;
  logic [3:0]           w_unch_next;

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= StSetup;
    else          r_state <= w_state_next;
  end

  // The game never returns to setup except through reset.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StSetup: if (i_start_game_switch) w_state_next = StRun;
      StRun:   if (i_gen_tick && !i_pause_switch) w_state_next = StEval;
      StEval:  w_state_next = StRun;
      default: w_state_next = StSetup;
    endcase
  end

  always_comb begin
    w_load_seed = (r_state == StSetup);
    w_sample    = (r_state == StRun) && i_gen_tick && !i_pause_switch;
    w_eval      = (r_state == StEval);
  end

  always_comb begin
    w_popcount = '0;
    for (int i = 0; i < 8; i++) w_popcount = w_popcount + 4'(i_neighbors[i]);
  end

  always_comb begin
    w_survive = r_alive && ((r_nbr_cnt == 4'd2) || (r_nbr_cnt == 4'd3));
`ifdef LIFE_HIGHLIFE_RULE_EN
    w_birth   = !r_alive && ((r_nbr_cnt == 4'd3) || (r_nbr_cnt == 4'd6));
`else
    w_birth   = !r_alive && (r_nbr_cnt == 4'd3);
`endif
    w_alive_next = w_survive || w_birth;
    w_flip       = (w_alive_next != r_alive);
    if (!w_alive_next)        w_age_next = '0;
    else if (w_birth)         w_age_next = AGE_WIDTH'(1);
    else if (r_age == AgeMax) w_age_next = AgeMax;
    else                      w_age_next = r_age + AGE_WIDTH'(1);
    w_unch_next = (r_unch_cnt == UnchMax) ? UnchMax : r_unch_cnt + 4'd1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_alive    <= 1'b0;
      r_changed  <= 1'b0;
      r_age      <= '0;
      r_stable   <= 1'b0;
      r_nbr_cnt  <= '0;
      r_unch_cnt <= '0;
    end else begin
      r_changed <= 1'b0;
      if (w_load_seed) begin
        r_alive <= i_seed;
        r_age   <= '0;
      end
      if (w_sample) r_nbr_cnt <= w_popcount;
      if (w_eval) begin
        r_alive   <= w_alive_next;
        r_age     <= w_age_next;
        r_changed <= w_flip;
        if (w_flip) begin
          r_unch_cnt <= '0;
          r_stable   <= 1'b0;
        end else begin
          r_unch_cnt <= w_unch_next;
          r_stable   <= ({1'b0, w_unch_next} >= StableThr);
        end
      end
    end
  end

  assign o_alive   = r_alive;
  assign o_changed = r_changed;
  assign o_age     = r_age;
  assign o_stable  = r_stable;

endmodule

// File: doc/life_cell_evolve.md
Name: life_cell_evolve

Overview:
- Per-cell generation engine downstream of the per-cell seed-selection FSM.
- Its `seed` input is that FSM's `selectingLightConfirmed` output.
- During setup it mirrors the confirmed seed. Once the game starts, it applies the Life rule on each board-wide generation tick, using the 8 neighbour alive bits.
- Outputs drive the cell LED and feed neighbouring cells; status outputs feed the board-level stable-pattern detector.

Parameters:
- AGE_WIDTH, 4: width of the saturating age counter (generations continuously alive).
- STABLE_GENS, 3: consecutive unchanged generations before `stable` asserts; legal range 1..15.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset; reset==0 at a posedge resets the block.
- seed  input  1  confirmed-seed level from the selection FSM.
- startGameSwitch  input  1  level; 1 leaves setup.
- pauseSwitch  input  1  level; 1 holds the current generation.
- genTick  input  1  one-cycle pulse from the board tick generator.
- neighbors  input  8  alive bits of the 8 adjacent cells; off-board neighbours are tied 0 at board level.
- alive  output  1  current cell state; drives LED and neighbours.
- changed  output  1  one-cycle pulse when a generation flips `alive`.
- age  output  AGE_WIDTH  generations alive, saturating.
- stable  output  1  level; cell unchanged for ≥ STABLE_GENS generations.

Behaviour:
- Reset (reset==0):
  - state=SETUP; alive=0, changed=0, age=0, stable=0.
  - Internal nbrCount=0, unchangedCnt=0.
  - Reset takes effect from any state, including mid-EVAL.
- States: SETUP, RUN, EVAL.
- SETUP:
  - alive <= seed every cycle; changed=0; age=0.
  - If startGameSwitch==1: next state RUN. The seed is sampled on that same edge, so alive holds the final seed.
  - genTick is ignored in SETUP.
- RUN:
  - If genTick==1 and pauseSwitch==0: nbrCount <= popcount(neighbors) (4-bit, 0..8), next state EVAL.
  - Otherwise stay in RUN.
  - neighbors is sampled only on the tick edge.
- EVAL (exactly one cycle, then back to RUN):
  - Survive: alive==1 and nbrCount∈{2,3} → alive stays 1; age <= age+1, saturating at all-ones.
  - Birth: alive==0 and nbrCount==3 → alive <= 1, age <= 1.
  - Death: alive==1 otherwise → alive <= 0, age <= 0.
  - Dead stays dead: age stays 0.
  - changed <= (new alive != old alive); it is high for exactly the one cycle after the EVAL edge, otherwise 0.
  - If changed: unchangedCnt <= 0 and stable <= 0.
  - Else: unchangedCnt <= sat(unchangedCnt+1); stable <= (unchangedCnt+1 ≥ STABLE_GENS).
- Latency: tick at edge k → new alive/changed/age/stable visible after edge k+1. All cells commit on the same edge, because all sample neighbours on edge k.
- A genTick arriving during EVAL is ignored; ticks are not queued.
- pauseSwitch==1 in RUN blocks new ticks. An EVAL already entered completes.
- startGameSwitch returning to 0 in RUN/EVAL has no effect. The game runs until reset (absorbing, like the confirmed states upstream).
- seed changes after SETUP are ignored.
- No arithmetic overflow: nbrCount is 4 bits; age and unchangedCnt saturate.

Optional Feature:
- Macro: LIFE_HIGHLIFE_RULE_EN.
- Defined: HighLife rule (B36/S23). Birth also occurs when alive==0 and nbrCount==6. Survival is unchanged.
- Undefined: standard Conway rule B3/S23 only. nbrCount==6 on a dead cell leaves it dead.

Test Plan:
- Reset then seed=1, startGameSwitch=1 for one edge → alive=1, age=0, state RUN; then seed=0 → alive stays 1.
- RUN, alive=1, neighbors=8'b00000011, genTick pulse → after 2 edges alive=1, age=1, changed=0; repeat 15 more ticks → age=15 (saturated), stable=1 from the 3rd tick onward.
- RUN, alive=0, neighbors=8'b00010101, tick → alive=1, age=1, changed high exactly one cycle; next tick with neighbors=8'h00 → alive=0, age=0, changed pulse, stable=0.
- alive=0, neighbors=8'b00111111 (6), tick → alive=0 without LIFE_HIGHLIFE_RULE_EN; alive=1, age=1 with it.
- pauseSwitch=1, three genTick pulses with neighbors=8'h00, alive=1 → alive stays 1, no changed pulse; genTick asserted on the EVAL cycle of a normal tick → only one generation applied.
- reset=0 asserted during EVAL → next cycle alive=0, age=0, stable=0, changed=0, state SETUP; subsequent genTick ignored.
